// File: rtl/lsu_pkg.sv
// Shared definitions for the M-stage load/store unit: funct3 size codes,
// FSM state encoding and the width of the optional BUSY timeout counter.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam int TO_CNT_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } lsu_state_t;

endpackage

// File: rtl/lsu_load_align.sv
// Picks the addressed byte/halfword lane out of a captured memory word and
// sign- or zero-extends it according to funct3.
module lsu_load_align
  import lsu_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  off,
  input  logic [2:0]  funct3,
  output logic [31:0] data
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  always_comb begin
    lane_b = 8'h00;
    case (off)
      2'd0:    lane_b = word[7:0];
      2'd1:    lane_b = word[15:8];
      2'd2:    lane_b = word[23:16];
      default: lane_b = word[31:24];
    endcase
    lane_h = off[1] ? word[31:16] : word[15:0];
  end

  always_comb begin
    data = 32'h0;
    case (funct3)
      F3_B:    data = {{24{lane_b[7]}}, lane_b};
      F3_H:    data = {{16{lane_h[15]}}, lane_h};
      F3_W:    data = word;
      F3_BU:   data = {24'h0, lane_b};
      F3_HU:   data = {16'h0, lane_h};
      default: data = 32'h0;
    endcase
  end

endmodule

// File: rtl/mem_lsu.sv
// M-stage load/store unit: turns the M-stage access into one word-bus
// transaction and stalls the pipeline until it completes.
// Optional BUSY timeout with bus-error pulse: define LSU_TIMEOUT_EN.
module mem_lsu
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 32
`ifdef LSU_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 255
`endif
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              MemReadM,
  input  logic              MemWriteM,
  input  logic [2:0]        Funct3M,
  input  logic [31:0]       ALUResultM,
  input  logic [31:0]       WriteDataM,
  output logic [31:0]       ReadDataM,
  output logic              StallM,
  output logic              MisalignM,
  output logic              BusErrM,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [31:0]       dmem_wdata,
  output logic [3:0]        dmem_be,
  input  logic              dmem_ready,
  input  logic [31:0]       dmem_rdata,
  output logic [1:0]        dbg_state
);

  // Bus handshake: dmem_req stays high with addr/we/be/wdata frozen until a
  // rising edge where dmem_ready=1; that edge completes the transfer and
  // dmem_rdata is taken with it. dmem_ready is ignored outside BUSY.

  lsu_state_t state, state_nx;

  logic [1:0]        off;
  logic              bad_f3;
  logic              bad_align;
  logic              access;
  logic              timeout;
  logic [3:0]        be_nx;
  logic [31:0]       wdata_nx;

  logic [ADDR_W-1:0] addr_q;
  logic              we_q;
  logic [3:0]        be_q;
  logic [31:0]       wdata_q;
  logic [1:0]        off_q;
  logic [2:0]        f3_q;
  logic [31:0]       rdata_q;
  logic [31:0]       aligned;
  logic              berr;

  assign off = ALUResultM[1:0];

  always_comb begin
    if (MemWriteM)
      bad_f3 = Funct3M[2] | (Funct3M[1] & Funct3M[0]);
    else
      bad_f3 = (Funct3M[1] & Funct3M[0]) | (Funct3M[2] & Funct3M[1]);
    bad_align = ((Funct3M[1:0] == 2'b01) && off[0]) ||
                ((Funct3M[1:0] == 2'b10) && (off != 2'b00));
    MisalignM = (MemReadM | MemWriteM) & (bad_f3 | bad_align);
    access    = (MemReadM | MemWriteM) & ~MisalignM;
  end

  always_comb begin
    be_nx    = 4'b1111;
    wdata_nx = WriteDataM;
    case (Funct3M[1:0])
      2'b00: begin
        be_nx    = 4'b0001 << off;
        wdata_nx = {4{WriteDataM[7:0]}};
      end
      2'b01: begin
        be_nx    = 4'b0011 << off;
        wdata_nx = {2{WriteDataM[15:0]}};
      end
      default: begin
        be_nx    = 4'b1111;
        wdata_nx = WriteDataM;
      end
    endcase
  end

`ifdef LSU_TIMEOUT_EN
  logic [TO_CNT_W-1:0] cnt_q;
  logic                berr_q;

  // A ready arriving in the expiry cycle wins, so timeout requires ready low.
  assign timeout = (state == BUSY) && !dmem_ready &&
                   (cnt_q == TO_CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q  <= '0;
      berr_q <= 1'b0;
    end else begin
      if (state == IDLE && access)
        cnt_q <= '0;
      else if (state == BUSY)
        cnt_q <= cnt_q + TO_CNT_W'(1);
      berr_q <= timeout;
    end
  end

  assign berr = berr_q;
`else
  assign timeout = 1'b0;
  assign berr    = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (access) state_nx = BUSY;
      BUSY:    if (dmem_ready || timeout) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addr_q  <= '0;
      we_q    <= 1'b0;
      be_q    <= 4'b0000;
      wdata_q <= 32'h0;
      off_q   <= 2'b00;
      f3_q    <= 3'b000;
      rdata_q <= 32'h0;
    end else begin
      if (state == IDLE && access) begin
        addr_q  <= {ALUResultM[ADDR_W-1:2], 2'b00};
        we_q    <= MemWriteM;
        be_q    <= be_nx;
        wdata_q <= wdata_nx;
        off_q   <= off;
        f3_q    <= Funct3M;
      end
      if (state == BUSY) begin
        if (dmem_ready) begin
          if (!we_q) rdata_q <= dmem_rdata;
        end else if (timeout) begin
          rdata_q <= 32'h0;
        end
      end
    end
  end

  lsu_load_align u_align (
    .word   (rdata_q),
    .off    (off_q),
    .funct3 (f3_q),
    .data   (aligned)
  );

  always_comb begin
    dmem_req  = (state == BUSY);
    StallM    = (state == BUSY) || ((state == IDLE) && access);
    ReadDataM = (state == DONE) ? aligned : 32'h0;
    BusErrM   = (state == DONE) && berr;
    dbg_state = state;
  end

  assign dmem_we    = we_q;
  assign dmem_addr  = addr_q;
  assign dmem_be    = be_q;
  assign dmem_wdata = wdata_q;

endmodule
